spi_flash_reader: RTL and testbench

Hardware read sequencer that drives the 8-bit SPI master core's register port as its only bus master, so that streaming reads from the serial configuration flash run without CPU involvement. A client supplies a 24-bit flash address and a byte count. The block then issues standard READ (0x03) plus the address, clocks out dummy bytes, and presents the received bytes on a valid/ready byte stream. It sits directly upstream of the SPI master core, in place of the CPU, and feeds a boot loader or DMA consumer.

---
 rtl/spi_flash_pkg.sv | 41 ++++
 rtl/spi_flash_reader_reg_access.sv | 67 ++++++
 rtl/spi_flash_reader.sv | 210 +++++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants and state encodings for the SPI flash read sequencer
// and its register-access engine.
package spi_flash_pkg;

  localparam logic [7:0]  READ_CMD   = 8'h03;
  localparam logic [15:0] SLAVE_MASK = 16'h0001;
  localparam logic [15:0] POLL_LIMIT = 16'd4095;

  localparam logic [2:0] REG_RXDATA   = 3'd0;
  localparam logic [2:0] REG_TXDATA   = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_CONTROL  = 3'd3;
  localparam logic [2:0] REG_SLAVESEL = 3'd5;

  localparam int ST_TMT   = 5;
  localparam int ST_TRDY  = 6;
  localparam int ST_RRDY  = 7;
  localparam int CTRL_SSO = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_SSO_ON,
    S_POLL_TX,
    S_WR_TX,
    S_POLL_RX,
    S_RD_RX,
    S_OUT,
    S_POLL_TMT,
    S_SSO_OFF,
    S_FIN
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_A0,
    PH_A1,
    PH_A2
  } phase_e;

endpackage

// File: rtl/spi_flash_reader_reg_access.sv
// Single-access engine for the SPI core register port: two strobed cycles
// followed by one released cycle, during which ack is raised.
module spi_reg_access
  import spi_flash_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        is_write_i,
  input  logic [2:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        ack_o,
  output logic [2:0]  spi_mem_addr_o,
  output logic        spi_select_o,
  output logic        spi_read_n_o,
  output logic        spi_write_n_o,
  output logic [15:0] spi_wdata_o,
  input  logic [15:0] spi_rdata_i
);

  phase_e      phase_q;
  logic        we_q;
  logic [2:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (start_i) begin
            phase_q <= PH_A0;
            we_q    <= is_write_i;
            addr_q  <= addr_i;
            wdata_q <= is_write_i ? wdata_i : 16'h0000;
          end
        end
        PH_A0: phase_q <= PH_A1;
        PH_A1: begin
          // core read data is registered, so it is valid by the end of A1
          phase_q <= PH_A2;
          if (!we_q) rdata_q <= spi_rdata_i;
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  // Outputs decode straight from reset registers so strobes drop with reset_n.
  assign active         = (phase_q == PH_A0) || (phase_q == PH_A1);
  assign spi_select_o   = active;
  assign spi_read_n_o   = !(active && !we_q);
  assign spi_write_n_o  = !(active && we_q);
  assign spi_mem_addr_o = active ? addr_q : 3'd0;
  assign spi_wdata_o    = active ? wdata_q : 16'h0000;
  assign ack_o          = (phase_q == PH_A2);
  assign rdata_o        = rdata_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Streaming flash reader: drives the SPI master core register port to issue
// READ + 24-bit address, then returns each received data byte on a stream.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter logic [15:0] POLL_MAX = spi_flash_pkg::POLL_LIMIT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_len,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  spi_mem_addr,
  output logic        spi_select,
  output logic        spi_read_n,
  output logic        spi_write_n,
  output logic [15:0] spi_wdata,
  input  logic [15:0] spi_rdata
);

  state_e      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [15:0] poll_q, poll_d;
  logic        tout_q, tout_d;
  logic [7:0]  dout_q, dout_d;

  logic        acc_start, acc_write, acc_ack;
  logic [2:0]  acc_addr;
  logic [15:0] acc_wdata, acc_rdata;
  logic [7:0]  tx_byte;
  logic        poll_hit;
  logic        unused_hi;

  assign unused_hi = ^acc_rdata[15:8];

  spi_reg_access u_acc (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (acc_start),
    .is_write_i     (acc_write),
    .addr_i         (acc_addr),
    .wdata_i        (acc_wdata),
    .rdata_o        (acc_rdata),
    .ack_o          (acc_ack),
    .spi_mem_addr_o (spi_mem_addr),
    .spi_select_o   (spi_select),
    .spi_read_n_o   (spi_read_n),
    .spi_write_n_o  (spi_write_n),
    .spi_wdata_o    (spi_wdata),
    .spi_rdata_i    (spi_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      poll_q  <= '0;
      tout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      poll_q  <= poll_d;
      tout_q  <= tout_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    tx_byte = READ_CMD;
      3'd1:    tx_byte = addr_q[23:16];
      3'd2:    tx_byte = addr_q[15:8];
      3'd3:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  assign poll_hit = ({1'b0, poll_q} + 17'd1) >= {1'b0, POLL_MAX};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    poll_d    = poll_q;
    tout_d    = tout_q;
    dout_d    = dout_q;
    acc_start = 1'b0;
    acc_write = 1'b0;
    acc_addr  = REG_STATUS;
    acc_wdata = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_SEL;
          addr_d  = req_addr;
          rem_d   = req_len;
          idx_d   = 3'd0;
          tout_d  = 1'b0;
        end
      end
      S_SEL: begin
        acc_write = 1'b1;
        acc_addr  = REG_SLAVESEL;
        acc_wdata = SLAVE_MASK;
        if (acc_ack) state_d = S_SSO_ON;
      end
      S_SSO_ON: begin
        acc_write = 1'b1;
        acc_addr  = REG_CONTROL;
        acc_wdata = 16'd1 << CTRL_SSO;
        if (acc_ack) state_d = S_POLL_TX;
      end
      S_POLL_TX: begin
        if (acc_ack) begin
          if (acc_rdata[ST_TRDY]) state_d = S_WR_TX;
          else if (poll_hit) begin
            state_d = S_SSO_OFF;
            tout_d  = 1'b1;
          end else poll_d = poll_q + 16'd1;
        end
      end
      S_WR_TX: begin
        acc_write = 1'b1;
        acc_addr  = REG_TXDATA;
        acc_wdata = {8'h00, tx_byte};
        if (acc_ack) state_d = S_POLL_RX;
      end
      S_POLL_RX: begin
        if (acc_ack) begin
          if (acc_rdata[ST_RRDY]) state_d = S_RD_RX;
          else if (poll_hit) begin
            state_d = S_SSO_OFF;
            tout_d  = 1'b1;
          end else poll_d = poll_q + 16'd1;
        end
      end
      S_RD_RX: begin
        acc_addr = REG_RXDATA;
        if (acc_ack) begin
          // idx saturates at 4, marking the data phase
          if (idx_q != 3'd4) begin
            idx_d   = idx_q + 3'd1;
            state_d = (idx_q == 3'd3 && rem_q == 16'd0) ? S_POLL_TMT : S_POLL_TX;
          end else begin
            dout_d  = acc_rdata[7:0];
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? S_POLL_TMT : S_POLL_TX;
        end
      end
      S_POLL_TMT: begin
        if (acc_ack) begin
          if (acc_rdata[ST_TMT]) state_d = S_SSO_OFF;
          else if (poll_hit) begin
            state_d = S_SSO_OFF;
            tout_d  = 1'b1;
          end else poll_d = poll_q + 16'd1;
        end
      end
      S_SSO_OFF: begin
        acc_write = 1'b1;
        acc_addr  = REG_CONTROL;
        if (acc_ack) state_d = S_FIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // One access per visit to a bus state; polls re-issue after each ack.
    if (state_q != S_IDLE && state_q != S_OUT && state_q != S_FIN && !pend_q) begin
      acc_start = 1'b1;
      pend_d    = 1'b1;
    end
    if (acc_ack) pend_d = 1'b0;
    if (state_d != state_q) poll_d = 16'd0;
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = dout_q;
  assign done      = (state_q == S_FIN) && !tout_q;
  assign err       = (state_q == S_FIN) && tout_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomised scoreboard bench: a behavioural SPI core + flash model answers
// the register port; monitors compare bus writes, bytes and completions.
`timescale 1ns/1ps
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done, err;
  logic [2:0]  spi_mem_addr;
  logic        spi_select, spi_read_n, spi_write_n;
  logic [15:0] spi_wdata;
  logic [15:0] spi_rdata;

  always #5 clk = ~clk;

  spi_flash_reader #(.POLL_MAX(16'd8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err),
    .spi_mem_addr(spi_mem_addr), .spi_select(spi_select), .spi_read_n(spi_read_n),
    .spi_write_n(spi_write_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_wr_q[$];
  logic [7:0]  exp_out_q[$];
  bit          exp_end_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] + a[15:8] + a[23:16] + 8'h37;
  endfunction

  function automatic logic [34:0] out_vec();
    return {req_ready, out_valid, out_data, busy, done, err, spi_select,
            spi_read_n, spi_write_n, spi_mem_addr, spi_wdata};
  endfunction

  localparam logic [34:0] RST_VEC = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 3'd0, 16'h0000};

  // SPI core + flash model: one byte shifts for shift_dly cycles after a txdata write.
  bit          stuck = 1'b0;
  int          shift_dly = 4;
  logic        trdy, rrdy, tmt;
  int          sh_cnt;
  logic [7:0]  rx_byte;
  int          nbytes;
  logic [23:0] faddr;
  logic        core_wr_prev, core_rd_prev;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trdy <= 1'b1; rrdy <= 1'b0; tmt <= 1'b1; sh_cnt <= 0; rx_byte <= 8'h00;
      nbytes <= 0; faddr <= '0; core_wr_prev <= 1'b0; core_rd_prev <= 1'b0;
      spi_rdata <= 16'h0000;
    end else begin
      core_wr_prev <= spi_select && !spi_write_n;
      core_rd_prev <= spi_select && !spi_read_n;
      if (sh_cnt != 0) begin
        sh_cnt <= sh_cnt - 1;
        if (sh_cnt == 1) begin rrdy <= 1'b1; trdy <= 1'b1; tmt <= 1'b1; end
      end
      if (spi_select && !spi_write_n && !core_wr_prev) begin
        if (spi_mem_addr == 3'd1) begin
          trdy <= 1'b0; tmt <= 1'b0; sh_cnt <= shift_dly;
          rx_byte <= (nbytes >= 4) ? flash_byte(faddr + 24'(nbytes - 4)) : 8'hFF;
          if (nbytes >= 1 && nbytes <= 3) faddr <= {faddr[15:0], spi_wdata[7:0]};
          nbytes <= nbytes + 1;
        end else if (spi_mem_addr == 3'd3 && spi_wdata == 16'h0400) begin
          nbytes <= 0;
        end
      end
      if (spi_select && !spi_read_n) begin
        case (spi_mem_addr)
          3'd0: begin
            spi_rdata <= {8'h00, rx_byte};
            if (!core_rd_prev) rrdy <= 1'b0;
          end
          3'd2:    spi_rdata <= {8'h00, rrdy, trdy & !stuck, tmt, 5'b00000};
          default: spi_rdata <= 16'h0000;
        endcase
      end
    end
  end

  // Monitors and out_ready driver
  int         run_len = 0;
  bit         wr_seen = 0, rd_seen = 0, prev_end = 0;
  int         status_reads = 0, tx_writes = 0;
  bit         hold_req = 0, rand_ready = 0;
  int         hold_cnt = 0, hold_snap = 0, out_cnt = 0;
  bit         held_v = 0;
  logic [7:0] held_d = '0;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      run_len = 0; wr_seen = 0; rd_seen = 0; prev_end = 0; held_v = 0; hold_cnt = 0;
      out_ready = 1'b1;
    end else begin
      if (!spi_read_n || !spi_write_n) begin
        run_len++;
        if (!spi_read_n && !spi_write_n) fail("strobe_overlap");
      end else if (run_len != 0) begin
        chk("strobe_len", run_len, 2);
        chk("bus_idle_after", {spi_select, spi_wdata}, 17'h0);
        run_len = 0;
      end
      if (spi_select && !spi_write_n && !wr_seen) begin
        if (exp_wr_q.size() == 0) fail("bus_write_unexpected");
        else chk("bus_write", {spi_mem_addr, spi_wdata}, exp_wr_q.pop_front());
        if (spi_mem_addr == 3'd1) tx_writes++;
      end
      wr_seen = spi_select && !spi_write_n;
      if (spi_select && !spi_read_n && !rd_seen && spi_mem_addr == 3'd2) status_reads++;
      rd_seen = spi_select && !spi_read_n;

      if (done || err) begin
        chk("end_pulse_width", {prev_end, done & err}, 2'b00);
        if (exp_end_q.size() == 0) fail("end_unexpected");
        else chk("end_kind_err", err, exp_end_q.pop_front());
      end
      prev_end = done || err;

      if (hold_cnt > 0) begin
        hold_cnt--;
        out_ready = 1'b0;
        if (hold_cnt == 0) chk("hold_no_tx", tx_writes, hold_snap);
      end else if (hold_req && out_valid && out_cnt == 1) begin
        hold_req = 0; hold_cnt = 50; hold_snap = tx_writes; out_ready = 1'b0;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end

      if (out_valid) begin
        if (held_v) chk("out_stable", out_data, held_d);
        if (out_ready) begin
          if (exp_out_q.size() == 0) fail("out_unexpected");
          else chk("out_data", out_data, exp_out_q.pop_front());
          out_cnt++;
          held_v = 0;
        end else begin
          held_v = 1; held_d = out_data;
        end
      end else held_v = 0;
    end
  end

  task automatic start_req(input logic [23:0] a, input logic [15:0] len, input bit stk, input int dly);
    stuck = stk; shift_dly = dly; status_reads = 0; out_cnt = 0;
    exp_wr_q.push_back({3'd5, 16'h0001});
    exp_wr_q.push_back({3'd3, 16'h0400});
    if (!stk) begin
      exp_wr_q.push_back({3'd1, 16'h0003});
      exp_wr_q.push_back({3'd1, 8'h00, a[23:16]});
      exp_wr_q.push_back({3'd1, 8'h00, a[15:8]});
      exp_wr_q.push_back({3'd1, 8'h00, a[7:0]});
      for (int i = 0; i < int'(len); i++) begin
        exp_wr_q.push_back({3'd1, 16'h0000});
        exp_out_q.push_back(flash_byte(a + 24'(i)));
      end
    end
    exp_wr_q.push_back({3'd3, 16'h0000});
    exp_end_q.push_back(stk);
    @(negedge clk);
    req_addr = a; req_len = len; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("busy_on", {busy, req_ready}, 2'b10);
  endtask

  task automatic wait_end(input bit stk);
    int n;
    n = 0;
    while (!(done || err) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail("wait_end_timeout");
    @(negedge clk);
    chk("busy_off", {busy, req_ready}, 2'b01);
    if (stk) chk("status_polls", status_reads, 8);
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("out_queue_drained", exp_out_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_values", out_vec(), RST_VEC);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    start_req(24'h012345, 16'd3, 1'b0, 6);
    wait_end(1'b0);

    start_req(24'h00ABCD, 16'd0, 1'b0, 3);
    wait_end(1'b0);

    hold_req = 1;
    start_req(24'h7F00FE, 16'd4, 1'b0, 5);
    wait_end(1'b0);
    chk("hold_happened", hold_req, 1'b0);
    hold_req = 0;

    start_req(24'h111111, 16'd2, 1'b1, 4);
    wait_end(1'b1);
    stuck = 1'b0;

    start_req(24'hABCDEF, 16'd2, 1'b0, 5);
    n = 0;
    while (nbytes != 3 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 2000) fail("reset_point_timeout");
    reset_n = 1'b0;
    #1;
    chk("reset_mid_op", out_vec(), RST_VEC);
    exp_wr_q.delete(); exp_out_q.delete(); exp_end_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    start_req(24'h5A5A5A, 16'd2, 1'b0, 4);
    wait_end(1'b0);

    rand_ready = 1;
    for (int t = 0; t < 10; t++) begin
      start_req(24'($urandom), 16'($urandom_range(0, 5)), 1'b0, int'($urandom_range(1, 12)));
      wait_end(1'b0);
    end
    rand_ready = 0;
    repeat (3) @(negedge clk);
    chk("end_queue_drained", exp_end_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
